misr_compactor: RTL and testbench

//  Parametrised multiple-input signature register (MISR) with a built-in session controller.

---
 rtl/misr_compactor_pkg.sv | 36 +++
 rtl/misr_compactor_core.sv | 36 +++
 rtl/misr_compactor.sv | 102 ++++++++++
 tb/tb_misr_compactor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/misr_compactor_pkg.sv
// Shared types and the MISR next-state function for the signature compactor.
// The step function works on a fixed maximum width so any WIDTH/NIN pair can use it.
package misr_compactor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  // Galois shift toward bit 0; the dropped LSB re-enters at the MSB and at every tapped stage.
  // Input bit d[k] is folded in at position width-1-k, so d[0] lands on the MSB.
  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input logic [MAX_W-1:0] d,
                                                 input int width,
                                                 input int nin);
    logic [MAX_W-1:0] n;
    logic [MAX_W-1:0] inj;
    logic             fb;
    fb  = s[0];
    n   = '0;
    inj = '0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < width - 1) n[i] = s[i+1] ^ (fb & poly[i]);
    end
    if (fb) n = n | (MAX_W'(1) << (width - 1));
    for (int k = 0; k < MAX_W; k++) begin
      if (k < nin) inj[MAX_W-1-k] = d[k];
    end
    return n ^ (inj >> (MAX_W - width));
  endfunction

endpackage

// File: rtl/misr_compactor_core.sv
// Signature register with synchronous load and step-enable; exposes the next step value.
module misr_core
  import misr_compactor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] poly_i,
  input  logic [NIN-1:0]   din_i,
  output logic [WIDTH-1:0] sig_o,
  output logic [WIDTH-1:0] step_o
);

  logic [WIDTH-1:0] sig_q, sig_d;

  assign step_o = WIDTH'(misr_step(MAX_W'(sig_q), MAX_W'(poly_i), MAX_W'(din_i), WIDTH, NIN));

  always_comb begin
    sig_d = sig_q;
    if (load_i)    sig_d = seed_i;
    else if (en_i) sig_d = step_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/misr_compactor.sv
// MISR response compactor with a session controller: load seed, compact a
// programmed number of valid beats, then compare the signature with a golden value.
module misr_compactor
  import misr_compactor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  input  logic [WIDTH-1:0] golden,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [NIN-1:0]   din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pass_q, pass_d;
  logic             load, en;
  logic [WIDTH-1:0] step;

  misr_core #(.WIDTH(WIDTH), .NIN(NIN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .en_i   (en),
    .seed_i (seed),
    .poly_i (poly),
    .din_i  (din),
    .sig_o  (sig),
    .step_o (step)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // abort wins over everything; a zero-length session completes on the start edge itself
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    load    = 1'b0;
    en      = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            load  = 1'b1;
            cnt_d = '0;
            if (num_patterns == '0) begin
              state_d = DONE;
              pass_d  = (seed == golden);
            end else begin
              state_d = RUN;
              pass_d  = 1'b0;
            end
          end
        end
        RUN: begin
          if (din_valid) begin
            en    = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == num_patterns) begin
              state_d = DONE;
              pass_d  = (step == golden);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Bench for misr_compactor: a 4-bit/1-input instance driven from a vector table and a
// default-size instance driven with random sessions checked against an arithmetic MISR model.
module tb_misr_compactor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 0, a_abort = 0, a_dv = 0;
  logic [3:0] a_seed = 0, a_poly = 0, a_golden = 0, a_sig;
  logic [7:0] a_num = 0;
  logic [0:0] a_din = 0;
  logic       a_busy, a_done, a_pass;

  logic        b_start = 0, b_abort = 0, b_dv = 0;
  logic [15:0] b_seed = 0, b_poly = 0, b_golden = 0, b_sig;
  logic [15:0] b_num = 0;
  logic [3:0]  b_din = 0;
  logic        b_busy, b_done, b_pass;

  misr_compactor #(.WIDTH(4), .NIN(1), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .seed(a_seed),
    .poly(a_poly), .golden(a_golden), .num_patterns(a_num), .din(a_din),
    .din_valid(a_dv), .sig(a_sig), .busy(a_busy), .done(a_done), .pass(a_pass));

  misr_compactor dut (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .seed(b_seed),
    .poly(b_poly), .golden(b_golden), .num_patterns(b_num), .din(b_din),
    .din_valid(b_dv), .sig(b_sig), .busy(b_busy), .done(b_done), .pass(b_pass));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signature as a right shift; a shifted-out 1 flips the tapped stages and sets the top bit.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] poly,
                                           input logic [31:0] d, input int w, input int n);
    logic [31:0] top, r;
    top = 32'd1 << (w - 1);
    r = s >> 1;
    if (s[0]) r = r ^ (poly & (top - 1)) ^ top;
    for (int k = 0; k < n; k++) if (d[k]) r = r ^ (top >> k);
    return r & ((top << 1) - 1);
  endfunction

  typedef struct {
    logic [3:0] seed;
    logic [3:0] poly;
    logic [3:0] golden;
    int         num;
    logic [3:0] dbits;
    logic [3:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[6];

  task automatic run4(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    a_seed = v.seed; a_poly = v.poly; a_golden = v.golden; a_num = 8'(v.num);
    a_start = 1;
    tick();
    a_start = 0;
    if (v.num == 0) chk({tag, "_busy0"}, a_busy, 0);
    for (int k = 0; k < v.num; k++) begin
      a_dv = 1; a_din = v.dbits[k];
      tick();
    end
    a_dv = 0;
    chk({tag, "_done"}, a_done, 1);
    chk({tag, "_pass"}, a_pass, v.exp_pass);
    chk({tag, "_sig"}, a_sig, v.exp_sig);
    chk({tag, "_busy"}, a_busy, 0);
  endtask

  logic [15:0] model, seed2, fin;
  logic [3:0]  dq[$];
  int          cyc, beats, num;
  logic        vld;

  initial begin
    tbl[0] = '{4'h1, 4'h3, 4'hA, 2, 4'b0001, 4'hA, 1'b1};
    tbl[1] = '{4'h1, 4'h3, 4'hB, 2, 4'b0001, 4'hA, 1'b0};
    tbl[2] = '{4'h8, 4'h3, 4'h2, 2, 4'b0000, 4'h2, 1'b1};
    tbl[3] = '{4'h0, 4'h9, 4'hE, 3, 4'b0111, 4'hE, 1'b1};
    tbl[4] = '{4'h5, 4'h3, 4'h5, 0, 4'b0000, 4'h5, 1'b1};
    tbl[5] = '{4'h5, 4'h3, 4'h6, 0, 4'b0000, 4'h5, 1'b0};

    #2;
    chk("rst_sig_b", b_sig, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_done_b", b_done, 0);
    chk("rst_pass_b", b_pass, 0);
    chk("rst_sig_a", a_sig, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // din_valid while idle must not disturb the signature
    b_dv = 1; b_din = 4'hF;
    repeat (3) tick();
    b_dv = 0;
    chk("idle_dv_sig", b_sig, 0);
    chk("idle_dv_busy", b_busy, 0);

    // first worked example, beat by beat
    a_seed = 4'h1; a_poly = 4'h3; a_golden = 4'hA; a_num = 8'd2;
    a_start = 1;
    tick();
    a_start = 0;
    chk("ex1_seed", a_sig, 4'h1);
    chk("ex1_busy", a_busy, 1);
    a_dv = 1; a_din = 1'b1;
    tick();
    chk("ex1_beat1", a_sig, 4'h3);
    chk("ex1_done_mid", a_done, 0);
    a_din = 1'b0;
    tick();
    a_dv = 0;
    chk("ex1_beat2", a_sig, 4'hA);
    chk("ex1_done", a_done, 1);
    chk("ex1_pass", a_pass, 1);

    for (int i = 0; i < 6; i++) run4(tbl[i], i);

    // random sessions; session 0 stalls on every other cycle
    for (int s = 0; s < 6; s++) begin
      b_seed = 16'($urandom);
      b_poly = 16'($urandom);
      num = (s == 0) ? 8 : $urandom_range(1, 12);
      b_num = 16'(num);
      dq.delete();
      fin = b_seed;
      for (int k = 0; k < num; k++) begin
        dq.push_back(4'($urandom));
        fin = 16'(ref_step(32'(fin), 32'(b_poly), 32'(dq[k]), 16, 4));
      end
      b_golden = (s % 2 == 0) ? fin : fin ^ 16'h0001;
      b_start = 1;
      tick();
      b_start = 0;
      model = b_seed;
      chk("rnd_seed", b_sig, 32'(model));
      cyc = 0; beats = 0;
      while (beats < num && cyc < 200) begin
        chk("rnd_busy", b_busy, 1);
        vld = (s == 0) ? cyc[0] : ($urandom_range(0, 2) != 0);
        b_dv = vld;
        b_din = vld ? dq[beats] : 4'($urandom);
        if (vld) begin
          model = 16'(ref_step(32'(model), 32'(b_poly), 32'(dq[beats]), 16, 4));
          beats++;
        end
        tick();
        cyc++;
        chk("rnd_sig", b_sig, 32'(model));
      end
      b_dv = 0;
      if (beats < num) begin
        n_cmp++; n_fail++;
        $display("FAIL rnd_budget: got %0d beats required %0d", beats, num);
      end
      if (s == 0) chk("alt_run_cycles", 32'(cyc), 16);
      chk("rnd_done", b_done, 1);
      chk("rnd_busy_end", b_busy, 0);
      chk("rnd_pass", b_pass, (s % 2 == 0) ? 1 : 0);
    end

    // abort on the third beat, then a fresh session
    b_seed = 16'h1234; b_poly = 16'hB400; b_num = 16'd8; b_golden = 16'h0;
    b_start = 1;
    tick();
    b_start = 0;
    model = b_seed;
    for (int k = 0; k < 2; k++) begin
      b_dv = 1; b_din = 4'(k + 5);
      model = 16'(ref_step(32'(model), 32'(b_poly), 32'(b_din), 16, 4));
      tick();
    end
    b_din = 4'h9; b_abort = 1;
    tick();
    b_abort = 0; b_dv = 0;
    chk("abort_busy", b_busy, 0);
    chk("abort_done", b_done, 0);
    chk("abort_sig_hold", b_sig, 32'(model));
    seed2 = 16'hACE1;
    b_seed = seed2; b_start = 1;
    tick();
    b_start = 0;
    chk("restart_seed", b_sig, 32'(seed2));
    model = seed2;
    for (int k = 0; k < 8; k++) begin
      b_dv = 1; b_din = 4'($urandom);
      b_start = (k == 3);
      b_seed = (k == 3) ? 16'hFFFF : seed2;
      model = 16'(ref_step(32'(model), 32'(b_poly), 32'(b_din), 16, 4));
      tick();
      if (k == 6) chk("restart_done_early", b_done, 0);
    end
    b_dv = 0; b_start = 0;
    chk("restart_done", b_done, 1);
    chk("start_in_run_ignored", b_sig, 32'(model));

    // asynchronous reset in the middle of a session
    b_seed = 16'h00FF; b_start = 1;
    tick();
    b_start = 0; b_dv = 1; b_din = 4'h3;
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    chk("arst_sig", b_sig, 0);
    chk("arst_busy", b_busy, 0);
    chk("arst_done", b_done, 0);
    chk("arst_pass", b_pass, 0);
    b_dv = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_busy", b_busy, 0);
    chk("post_rst_sig", b_sig, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
